// File: rtl/level_pkg.sv
// Shared definitions for the level input conditioning path: FSM state
// encodings, default parameter values and a small width helper.
package level_pkg;

   // Filter FSM states. LO/HI are settled levels; the CHK states are
   // qualifying a candidate transition towards the opposite level.
   typedef enum logic [1:0] {
      ST_LO     = 2'd0,
      ST_CHK_HI = 2'd1,
      ST_HI     = 2'd2,
      ST_CHK_LO = 2'd3
   } level_state_e;

   // Default build values.
   localparam int LEVEL_SYNC_STAGES     = 2;
   localparam int LEVEL_DEBOUNCE_CYCLES = 4;
   localparam int LEVEL_CNT_W           = 8;

   // Qualify counter width: one spare bit above what DEBOUNCE_CYCLES-1 needs.
   function automatic int level_qcnt_w(input int debounce_cycles);
      return $clog2(debounce_cycles) + 1;
   endfunction

endpackage

// File: rtl/level_sync.sv
// Multi-flop synchroniser bringing the raw asynchronous level into the clk
// domain. All stages reset asynchronously to 0.
module level_sync
   import level_pkg::*;
#(
   parameter int SYNC_STAGES = LEVEL_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain_q;

   // Shift the raw input one stage deeper each clock; stage 0 may go metastable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/level_in_filter.sv
// Input conditioner for the level0 inverter chain: synchronises the raw
// level, debounces it, and drives a clean registered level plus one-cycle
// rise/fall strobes. The FSM state is held in state_q for probing.
// Optional feature: define LEVEL_IN_FILTER_EDGE_CNT_EN to build the
// committed-edge counter on edge_cnt; otherwise edge_cnt is tied to 0.
module level_in_filter
   import level_pkg::*;
#(
   parameter int SYNC_STAGES     = LEVEL_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = LEVEL_DEBOUNCE_CYCLES,
   parameter int CNT_W           = LEVEL_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   output logic             out,
   output logic             rise,
   output logic             fall,
   output logic             busy,
   output logic [CNT_W-1:0] edge_cnt
);

   localparam int            QW     = level_qcnt_w(DEBOUNCE_CYCLES);
   localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE_CYCLES - 1);
   localparam logic [QW-1:0] Q_ONE  = QW'(1);

   logic           s;
   level_state_e   state_q, state_d;
   logic [QW-1:0]  qcnt_q, qcnt_d;
   logic           out_q, out_d;
   logic           rise_q, rise_d;
   logic           fall_q, fall_d;
   logic           busy_q, busy_d;

   level_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (in),
      .q  (s)
   );

   // State, qualify counter and all outputs are registered together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LO;
         qcnt_q  <= '0;
         out_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   // Next state: a candidate level must be seen DEBOUNCE_CYCLES consecutive
   // synced cycles before it commits; any reverted sample, including one on
   // the would-be commit cycle, drops back to the settled state.
   always_comb begin
      state_d = state_q;
      qcnt_d  = qcnt_q;
      out_d   = out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         ST_LO: begin
            if (s) begin
               state_d = ST_CHK_HI;
               qcnt_d  = Q_ONE;
               busy_d  = 1'b1;
            end
         end
         ST_CHK_HI: begin
            if (!s) begin
               state_d = ST_LO;
               qcnt_d  = '0;
               busy_d  = 1'b0;
            end else if (qcnt_q == Q_LAST) begin
               state_d = ST_HI;
               qcnt_d  = '0;
               out_d   = 1'b1;
               rise_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               qcnt_d = qcnt_q + Q_ONE;
            end
         end
         ST_HI: begin
            if (!s) begin
               state_d = ST_CHK_LO;
               qcnt_d  = Q_ONE;
               busy_d  = 1'b1;
            end
         end
         ST_CHK_LO: begin
            if (s) begin
               state_d = ST_HI;
               qcnt_d  = '0;
               busy_d  = 1'b0;
            end else if (qcnt_q == Q_LAST) begin
               state_d = ST_LO;
               qcnt_d  = '0;
               out_d   = 1'b0;
               fall_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               qcnt_d = qcnt_q + Q_ONE;
            end
         end
         default: begin
            state_d = ST_LO;
            qcnt_d  = '0;
            out_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign out  = out_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

`ifdef LEVEL_IN_FILTER_EDGE_CNT_EN
   logic [CNT_W-1:0] edge_cnt_q;

   // Count on the commit edge so the new count appears alongside the strobe;
   // wraps naturally modulo 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt_q <= '0;
      end else if (rise_d || fall_d) begin
         edge_cnt_q <= edge_cnt_q + CNT_W'(1);
      end
   end

   assign edge_cnt = edge_cnt_q;
`else
   assign edge_cnt = '0;
`endif

endmodule

// File: tb/tb_level_in_filter.sv
// Self-checking bench for level_in_filter. The reference model treats the
// filter as "input delayed by SYNC_STAGES, then a level flips once the last
// DEBOUNCE_CYCLES delayed samples all disagree with it".
module tb_level_in_filter;

   localparam int SYNC  = 2;
   localparam int DEB   = 4;
   localparam int CNT_W = 2;
   localparam int W     = 4 + CNT_W;

   logic             clk;
   logic             rst;
   logic             din;
   logic             out;
   logic             rise;
   logic             fall;
   logic             busy;
   logic [CNT_W-1:0] edge_cnt;

   level_in_filter #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W          (CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in      (din),
      .out     (out),
      .rise    (rise),
      .fall    (fall),
      .busy    (busy),
      .edge_cnt(edge_cnt)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters / scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are stable at the falling edge; one expected entry per
   // modelled rising edge.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_outputs", {28'd0, out, rise, fall, busy, edge_cnt}, {28'd0, e});
         end
      end
   end

   // ---------------- reference model ----------------
   logic             m_out;
   logic [CNT_W-1:0] m_cnt;
   logic             dly[$];
   logic             win[$];

   task automatic model_reset();
      m_out = 1'b0;
      m_cnt = '0;
      dly.delete();
      for (int i = 0; i < SYNC; i++) dly.push_back(1'b0);
      win.delete();
   endtask

   task automatic model_edge(input logic v);
      logic s, r, f, b;
      int   k;
      s = dly.pop_front();
      dly.push_back(v);
      win.push_back(s);
      if (win.size() > DEB) void'(win.pop_front());
      k = 0;
      for (int i = win.size() - 1; i >= 0; i--) begin
         if (win[i] != m_out) k++;
         else break;
      end
      r = 1'b0;
      f = 1'b0;
      b = 1'b0;
      if (k == DEB) begin
         m_out = ~m_out;
         r = m_out;
         f = ~m_out;
`ifdef LEVEL_IN_FILTER_EDGE_CNT_EN
         m_cnt = m_cnt + 1'b1;
`endif
      end else begin
         b = (k > 0);
      end
      exp_q.push_back({m_out, r, f, b, m_cnt});
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a falling edge; returns just after the next one.
   task automatic step(input logic v);
      din = v;
      @(posedge clk);
      model_edge(v);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_out",  {31'd0, out},  32'd0);
      check("rst_rise", {31'd0, rise}, 32'd0);
      check("rst_fall", {31'd0, fall}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cnt",  {{(32-CNT_W){1'b0}}, edge_cnt}, 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Drive v until the given strobe appears; returns cycles taken (bounded).
   task automatic measure(input logic v, input logic want_rise, output int n);
      n = 0;
      for (int i = 1; i <= 16; i++) begin
         step(v);
         if ((want_rise && rise) || (!want_rise && fall)) begin
            n = i;
            break;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int   n;
      int   seen_busy;
      int   seen_edge;
      logic v;

      rst = 1'b0;
      din = 1'b1;
      #2;
      // Reset asserted with in high; held high through release.
      do_reset();

      // Re-qualification from ST_LO after reset: full latency.
      measure(1'b1, 1'b1, n);
      check("rise_latency_after_reset", n, SYNC + DEB);

      // Clean fall after a rise.
      measure(1'b0, 1'b0, n);
      check("fall_latency", n, SYNC + DEB);
      check("out_after_fall", {31'd0, out}, 32'd0);
`ifdef LEVEL_IN_FILTER_EDGE_CNT_EN
      check("cnt_after_two_edges", {{(32-CNT_W){1'b0}}, edge_cnt}, 32'd2);
`else
      check("cnt_tied_zero", {{(32-CNT_W){1'b0}}, edge_cnt}, 32'd0);
`endif
      for (int i = 0; i < 4; i++) step(1'b0);

      // Glitch reject: three cycles high, one short of committing.
      seen_busy = 0;
      seen_edge = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         if (busy) seen_busy++;
         if (rise || fall) seen_edge++;
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0);
         if (busy) seen_busy++;
         if (rise || fall) seen_edge++;
      end
      check("glitch_busy_cycles", seen_busy, 3);
      check("glitch_no_edge", seen_edge, 0);
      check("glitch_out_low", {31'd0, out}, 32'd0);

      // Clean rise from idle, then reset two cycles into ST_CHK_LO.
      measure(1'b1, 1'b1, n);
      check("rise_latency", n, SYNC + DEB);
      for (int i = 0; i < 2; i++) step(1'b1);
      for (int i = 0; i < SYNC + 2; i++) step(1'b0);
      check("chk_lo_busy", {31'd0, busy}, 32'd1);
      do_reset();
      seen_edge = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0);
         if (rise || fall) seen_edge++;
      end
      check("reset_mid_qual_no_strobe", seen_edge, 0);

      // Five committed edges to exercise counter wrap.
      for (int e = 0; e < 5; e++) begin
         for (int i = 0; i < SYNC + DEB + 1; i++) step(e % 2 == 0);
      end

      // Randomised segments, with an occasional reset.
      for (int seg = 0; seg < 120; seg++) begin
         v = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 2 * DEB + 2);
         for (int i = 0; i < n; i++) step(v);
         if ($urandom_range(0, 39) == 0) do_reset();
      end
      for (int i = 0; i < SYNC + DEB + 2; i++) step(1'b0);

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global bound in case something stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
